mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
- Beat sequencer between the external memory bus and the cache-line shift register.
- Moves one cache line per request as CASH_STR_WIDTH/SHIFT_LEN bus beats:
  - Fill: memory to line.
  - Writeback: line to memory.
- Drives the shift register's load, mode and shift controls and its serial data input.
- Owns the memory handshake, beat counting and a completion pulse to the cache controller.

Parameters:
- CASH_STR_WIDTH, 64: cache line width in bits; must be an integer multiple of SHIFT_LEN.
- SHIFT_LEN, 32: memory bus beat width in bits.
- ADDR_WIDTH, 32: word address width; the low BEAT_BITS bits address the beat within the line.
- TIMEOUT_CYCLES, 255: per-beat ack watchdog limit, in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- not_reset  in  1  reset, asynchronous, active-low
- req_valid  in  1  cache requests a burst
- req_we  in  1  0 = line fill, 1 = writeback
- req_addr  in  ADDR_WIDTH  word address of the line; beat bits are ignored
- req_ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when the burst completes
- err  out  1  one-cycle pulse on abort; tied 0 without the optional feature
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_WIDTH  {line base, beat_cnt}
- mem_wdata  out  SHIFT_LEN  write data; equals sr_dout_lo
- mem_rdata  in  SHIFT_LEN  read data, valid with mem_ack
- mem_ack  in  1  current beat completes this cycle
- sr_load  out  1  shift register load
- sr_mode  out  1  0 = parallel load, 1 = serial load from the top
- sr_shift  out  1  shift right by SHIFT_LEN
- sr_din_b  out  SHIFT_LEN  serial load data; equals mem_rdata
- sr_dout_lo  in  SHIFT_LEN  bits [SHIFT_LEN-1:0] of the shift register output

Behaviour:
- Derived constants: BEATS = CASH_STR_WIDTH/SHIFT_LEN; BEAT_BITS = clog2(BEATS).
- Registers: state, beat_cnt (BEAT_BITS wide), addr_q, we_q.
- Reset:
  - state = IDLE; beat_cnt = 0; addr_q = 0.
  - All outputs 0 except req_ready = 1.
  - Reset asserted mid-burst drops mem_req immediately and abandons the burst; no done or err is issued.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_addr and req_we and clear beat_cnt.
  - Next state: RD_BEAT if req_we = 0, else WR_LOAD.
- RD_BEAT:
  - mem_req = 1, mem_we = 0.
  - On mem_ack: sr_load = 1, sr_mode = 1 (combinational from mem_ack), sr_din_b = mem_rdata, beat_cnt + 1.
  - On the ack of beat BEATS-1, go to DONE.
  - Beat 0 ends up in the low word of the line.
- WR_LOAD:
  - One cycle with sr_load = 1, sr_mode = 0; the cache drives the line onto the shift register din.
  - Next state WR_BEAT.
- WR_BEAT:
  - mem_req = 1, mem_we = 1, mem_wdata = sr_dout_lo.
  - On mem_ack: sr_shift = 1, beat_cnt + 1.
  - On the ack of the last beat, go to DONE.
- DONE: done = 1 for one cycle, then IDLE. A new request can be accepted the cycle after DONE.
- mem_req and mem_addr are held stable until mem_ack; wait states of any length are legal.
- req_valid while not in IDLE is ignored.
- sr_load and sr_shift are never asserted together.
- Latency with zero-wait ack, accept at cycle T:
  - Fill: done at T+BEATS+1.
  - Writeback: done at T+BEATS+2.
- beat_cnt wraps to 0 after the last beat; the state change masks the wrap.

Optional Feature:
- Macro: MEM_BURST_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles with mem_req = 1 and mem_ack = 0; it clears on every ack.
  - On reaching TIMEOUT_CYCLES: err pulses for one cycle, mem_req drops, state returns to IDLE, and done is not issued.
  - The shift register contents are then undefined.
- Undefined: no watchdog; err is tied 0; the controller waits for mem_ack indefinitely.

Decomposition:
- Shared package mem_burst_pkg:
  - State enum: IDLE, RD_BEAT, WR_LOAD, WR_BEAT, DONE.
  - BEATS and BEAT_BITS derivation functions.
  - Default bus widths.
- Natural sub-module: mem_burst_wdog, the watchdog counter, instantiated only under MEM_BURST_TIMEOUT_EN.
- The shift register itself is instantiated alongside this block, not inside it.

Test Plan (defaults, so BEATS = 2):
- Fill, addr 0x100, zero-wait ack, rdata 0x11111111 then 0x22222222 -> mem_addr 0x100, 0x101; shift register holds 0x22222222_11111111; done at T+3.
- Writeback, line 0xAAAA5555_CCCC3333, zero-wait ack -> WR_LOAD at T+1; mem_wdata 0xCCCC3333 then 0xAAAA5555; done at T+4.
- Fill with 3 wait cycles per beat -> mem_req and mem_addr stable throughout; exactly two sr_load pulses; done at T+9.
- req_valid held high during a busy burst -> the second request is accepted only the cycle after done; no extra beats issued.
- not_reset pulsed low during writeback beat 1 -> mem_req = 0 immediately; req_ready = 1 after release; no done.
- With MEM_BURST_TIMEOUT_EN, TIMEOUT_CYCLES = 4, ack withheld -> err pulses 4 cycles after mem_req rises; state returns to IDLE; done stays 0.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared definitions for the memory burst controller slice.
// Holds the burst FSM state encoding, the default bus widths and the
// helpers that derive the beat count and beat-index width from the line
// and bus widths.
package mem_burst_pkg;

  localparam int DEF_CASH_STR_WIDTH = 64;
  localparam int DEF_SHIFT_LEN      = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    RD_BEAT,
    WR_LOAD,
    WR_BEAT,
    DONE
  } burst_state_e;

  // Number of bus beats that make up one cache line.
  function automatic int calc_beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  // Width of the beat index; a one-beat line still gets a 1-bit counter
  // so that no zero-width vector is ever declared.
  function automatic int calc_beat_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// External memory bus seen by the burst controller.
// master (controller): drives mem_req, mem_we, mem_addr, mem_wdata;
//                      receives mem_rdata, mem_ack.
// slave  (memory):     the mirror image.
// mem_req/mem_addr are held until mem_ack; mem_rdata is valid with mem_ack.
interface mem_burst_ctrl_if
  import mem_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SHIFT_LEN  = DEF_SHIFT_LEN
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [SHIFT_LEN-1:0]  mem_wdata;
  logic [SHIFT_LEN-1:0]  mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_burst_wdog.sv
// Per-beat acknowledge watchdog for the burst controller.
// Ports: clk, not_reset (async, active-low); active = a beat request is
// outstanding; ack = the memory acknowledged this cycle; timeout = the
// beat has waited LIMIT cycles without an ack (held until the controller
// drops active, which it does on the following edge).
module mem_burst_wdog
  import mem_burst_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic not_reset,
  input  logic active,
  input  logic ack,
  output logic timeout
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (wait_cnt == LIMIT_V);

  // Count unacknowledged request cycles; any ack, an idle bus or the
  // abort itself restarts the count for the next beat.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      wait_cnt <= '0;
    end else if (!active || ack || timeout) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Beat sequencer between the external memory bus and the cache-line shift
// register. Moves one line per request as BEATS bus beats (fill: memory
// to line, writeback: line to memory) and pulses done on completion.
// Ports: clk, not_reset (async, active-low); req_valid/req_we/req_addr/
// req_ready request handshake from the cache; done/err completion pulses;
// mem (mem_burst_ctrl_if.master) memory bus; sr_load/sr_mode/sr_shift/
// sr_din_b shift register controls and serial data; sr_dout_lo low word
// of the shift register.
// Build option: define MEM_BURST_TIMEOUT_EN to add the per-beat ack
// watchdog that aborts a stalled burst and pulses err.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int CASH_STR_WIDTH = DEF_CASH_STR_WIDTH,
  parameter int SHIFT_LEN      = DEF_SHIFT_LEN,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  not_reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  done,
  output logic                  err,
  mem_burst_ctrl_if.master      mem,
  output logic                  sr_load,
  output logic                  sr_mode,
  output logic                  sr_shift,
  output logic [SHIFT_LEN-1:0]  sr_din_b,
  input  logic [SHIFT_LEN-1:0]  sr_dout_lo
);

  localparam int BEATS     = calc_beats(CASH_STR_WIDTH, SHIFT_LEN);
  localparam int BEAT_BITS = calc_beat_bits(BEATS);
  localparam logic [BEAT_BITS-1:0]  LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BEATS - 1);

  burst_state_e          state, state_d;
  logic [BEAT_BITS-1:0]  beat_cnt, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  beat_active;
  logic                  beat_ack;
  logic                  last_beat;
  logic                  timeout;

`ifdef MEM_BURST_TIMEOUT_EN
  mem_burst_wdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .not_reset(not_reset),
    .active   (beat_active),
    .ack      (mem.mem_ack),
    .timeout  (timeout)
  );
  assign err = timeout;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // An ack arriving in the abort cycle is ignored so the burst never
  // advances and aborts at the same time.
  assign beat_ack  = mem.mem_ack && !timeout;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // addr_q keeps the line base with its beat bits cleared, so the beat
  // index can simply be OR-ed in.
  assign mem.mem_req   = beat_active && !timeout;
  assign mem.mem_we    = beat_active && we_q;
  assign mem.mem_addr  = addr_q | ADDR_WIDTH'(beat_cnt);
  assign mem.mem_wdata = sr_dout_lo;
  assign sr_din_b      = mem.mem_rdata;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
    end
  end

  always_comb begin
    state_d     = state;
    beat_cnt_d  = beat_cnt;
    addr_d      = addr_q;
    we_d        = we_q;
    req_ready   = 1'b0;
    done        = 1'b0;
    beat_active = 1'b0;
    sr_load     = 1'b0;
    sr_mode     = 1'b0;
    sr_shift    = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d     = req_addr & ~BEAT_MASK;
          we_d       = req_we;
          beat_cnt_d = '0;
          state_d    = req_we ? WR_LOAD : RD_BEAT;
        end
      end
      RD_BEAT: begin
        beat_active = 1'b1;
        if (beat_ack) begin
          sr_load    = 1'b1;
          sr_mode    = 1'b1;
          beat_cnt_d = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR_LOAD: begin
        sr_load = 1'b1;
        state_d = WR_BEAT;
      end
      WR_BEAT: begin
        beat_active = 1'b1;
        if (beat_ack) begin
          sr_shift   = 1'b1;
          beat_cnt_d = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end
  end

endmodule
